// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and helpers for the parametrised register file.
//   state_t       - init sequencer states (INIT, READY)
//   INIT_ZERO     - INIT_MODE value: every register loads 0
//   INIT_INDEX    - INIT_MODE value: register i loads i, zero-extended
//   init_value()  - init word for a given mode and register index; returned
//                   at MAX_XLEN bits, callers narrow it to their XLEN
package regfile_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;
    localparam int MAX_XLEN   = 128;

    function automatic logic [MAX_XLEN-1:0] init_value(input int mode, input logic [31:0] idx);
        logic [MAX_XLEN-1:0] v;
        v = '0;
        if (mode == INIT_INDEX) begin
            v[31:0] = idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// regfile_init_seq: walks every register index once after reset or on
// request, then holds READY until the next init_req.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   init_req  in   re-run request, honoured only in READY
//   init_we   out  high while the sequencer owns the write port
//   init_idx  out  register index being initialised this cycle
//   ready     out  registered decode of the READY state
module regfile_init_seq #(
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          init_req,
    output logic          init_we,
    output logic [AW-1:0] init_idx,
    output logic          ready
);
    import regfile_pkg::*;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q,   idx_d;
    logic          ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            INIT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = READY;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            READY: begin
                if (init_req) begin
                    state_d = INIT;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                idx_d   = '0;
            end
        endcase
        // ready is decoded from the next state so it is a plain flop output
        // and init_req never reaches it combinationally.
        ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    assign init_we  = (state_q == INIT);
    assign init_idx = idx_q;
    assign ready    = ready_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: integer register file, two combinational read ports, one
// clocked write port, hardwired zero register, self-initialising contents.
// Build option: define REGFILE_BYPASS_EN for write-first reads (a read of
// the register being written this cycle returns WriteData); otherwise reads
// are read-first.
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   init_req              re-run the init sequence (taken only when ready)
//   RegWrite, rd, WriteData   user write port
//   rs1, rs2              read indices
//   ReadData1, ReadData2  read data, forced to 0 while not ready
//   ready                 file accepts writes and returns stored data
module regfile_param #(
    parameter  int XLEN      = 64,
    parameter  int DEPTH     = 32,
    parameter  int INIT_MODE = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            init_req,
    input  logic            RegWrite,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] WriteData,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] ReadData1,
    output logic [XLEN-1:0] ReadData2,
    output logic            ready
);
    import regfile_pkg::*;

    logic            init_we;
    logic [AW-1:0]   init_idx;
    logic            user_we;
    logic            wr_en;
    logic [AW-1:0]   wr_idx;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] init_word;

    // Storage is deliberately not reset; the init sequencer defines it.
    logic [XLEN-1:0] regs_q [DEPTH];

    regfile_init_seq #(
        .DEPTH (DEPTH)
    ) u_init_seq (
        .clk      (clk),
        .reset    (reset),
        .init_req (init_req),
        .init_we  (init_we),
        .init_idx (init_idx),
        .ready    (ready)
    );

    // User writes only land in READY and never target register 0.
    assign user_we = ready && RegWrite && (rd != '0);

    always_comb begin
        init_word = XLEN'(init_value(INIT_MODE, 32'(init_idx)));
        wr_en     = 1'b0;
        wr_idx    = '0;
        wr_data   = '0;
        if (init_we) begin
            wr_en   = 1'b1;
            wr_idx  = init_idx;
            wr_data = init_word;
        end else if (user_we) begin
            wr_en   = 1'b1;
            wr_idx  = rd;
            wr_data = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            regs_q[wr_idx] <= wr_data;
        end
    end

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (ready) begin
            if (rs1 != '0) begin
                ReadData1 = regs_q[rs1];
`ifdef REGFILE_BYPASS_EN
                if (user_we && (rd == rs1)) begin
                    ReadData1 = WriteData;
                end
`endif
            end
            if (rs2 != '0) begin
                ReadData2 = regs_q[rs2];
`ifdef REGFILE_BYPASS_EN
                if (user_we && (rd == rs2)) begin
                    ReadData2 = WriteData;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

    localparam int DEPTH  = 32;
    localparam int DEPTH2 = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_req;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [63:0] WriteData;
    logic [4:0]  rs1, rs2;
    logic [63:0] ReadData1, ReadData2;
    logic        ready;

    // Second build: XLEN=32, DEPTH=16, zero init
    logic        init_req2;
    logic        we2;
    logic [3:0]  rd2;
    logic [31:0] wd2;
    logic [3:0]  ra2, rb2;
    logic [31:0] q2a, q2b;
    logic        rdy2;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as seen once ready, plus remaining init cycles
    logic [63:0] mem_m [DEPTH];
    logic        ready_m;
    int          init_cnt;
    logic        ready2_m;
    int          init_cnt2;

    regfile_param #(.XLEN(64), .DEPTH(DEPTH), .INIT_MODE(1)) dut (
        .clk(clk), .reset(reset), .init_req(init_req), .RegWrite(RegWrite),
        .rd(rd), .WriteData(WriteData), .rs1(rs1), .rs2(rs2),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .ready(ready)
    );

    regfile_param #(.XLEN(32), .DEPTH(DEPTH2), .INIT_MODE(0)) dut2 (
        .clk(clk), .reset(reset), .init_req(init_req2), .RegWrite(we2),
        .rd(rd2), .WriteData(wd2), .rs1(ra2), .rs2(rb2),
        .ReadData1(q2a), .ReadData2(q2b), .ready(rdy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] rs);
        if (!ready_m || rs == 5'd0) return 64'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWrite && rd != 5'd0 && rd == rs) return WriteData;
`endif
        return mem_m[rs];
    endfunction

    task automatic set_reset(input logic v);
        reset = v;
        if (v) begin
            ready_m   = 1'b0;
            init_cnt  = DEPTH;
            ready2_m  = 1'b0;
            init_cnt2 = DEPTH2;
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            ready_m  = 1'b0;
            init_cnt = DEPTH;
        end else if (ready_m) begin
            if (RegWrite && rd != 5'd0) mem_m[rd] = WriteData;
            if (init_req) begin
                ready_m  = 1'b0;
                init_cnt = DEPTH;
            end
        end else begin
            init_cnt--;
            if (init_cnt == 0) begin
                for (int i = 0; i < DEPTH; i++) mem_m[i] = 64'(i);
                ready_m = 1'b1;
            end
        end
        if (reset) begin
            ready2_m  = 1'b0;
            init_cnt2 = DEPTH2;
        end else if (!ready2_m) begin
            init_cnt2--;
            if (init_cnt2 == 0) ready2_m = 1'b1;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cyc();
        #1;
        check("rd1", ReadData1, exp_read(rs1));
        check("rd2", ReadData2, exp_read(rs2));
        check("ready", {63'd0, ready}, {63'd0, ready_m});
        check("ready2", {63'd0, rdy2}, {63'd0, ready2_m});
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        init_req  = 1'b0;
        RegWrite  = 1'b0;
        rd        = 5'd0;
        WriteData = 64'd0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 64'd0;
        init_req2 = 1'b0; we2 = 1'b0; rd2 = 4'd0; wd2 = 32'd0; ra2 = 4'd0; rb2 = 4'd0;
        idle_inputs();
        rs1 = 5'd5; rs2 = 5'd31;
        set_reset(1'b1);
        @(negedge clk);
        cyc();
        cyc();
        set_reset(1'b0);

        // INIT after reset: inputs randomised, all must be ignored
        for (int c = 0; c < DEPTH; c++) begin
            RegWrite  = 1'($urandom_range(1));
            init_req  = 1'($urandom_range(1));
            rd        = 5'($urandom_range(31));
            WriteData = {$urandom, $urandom};
            rs1       = 5'($urandom_range(31));
            rs2       = 5'($urandom_range(31));
            cyc();
        end
        idle_inputs();
        rs1 = 5'd5; rs2 = 5'd31;
        #1;
        check("ready_up", {63'd0, ready}, 64'd1);
        check("rs1_5", ReadData1, 64'd5);
        check("rs2_31", ReadData2, 64'd31);
        cyc();

        // Second build: zero init, full-width write
        for (int i = 0; i < DEPTH2; i++) begin
            ra2 = 4'(i); rb2 = 4'(DEPTH2 - 1 - i);
            #1;
            check("z_a", {32'd0, q2a}, 64'd0);
            check("z_b", {32'd0, q2b}, 64'd0);
        end
        we2 = 1'b1; rd2 = 4'd15; wd2 = 32'hFFFF_FFFF; ra2 = 4'd1;
        cyc();
        we2 = 1'b0; ra2 = 4'd15; rb2 = 4'd15;
        #1;
        check("z_w15a", {32'd0, q2a}, 64'h0000_0000_FFFF_FFFF);
        check("z_w15b", {32'd0, q2b}, 64'h0000_0000_FFFF_FFFF);

        // Basic write / read back, write to x0 dropped
        RegWrite = 1'b1; rd = 5'd7; WriteData = 64'hDEAD_BEEF; rs1 = 5'd1; rs2 = 5'd2;
        cyc();
        RegWrite = 1'b0; rs1 = 5'd7;
        #1;
        check("w7", ReadData1, 64'hDEAD_BEEF);
        cyc();
        RegWrite = 1'b1; rd = 5'd0; WriteData = 64'h1234; rs1 = 5'd0; rs2 = 5'd0;
        cyc();
        RegWrite = 1'b0;
        #1;
        check("x0", ReadData1, 64'd0);
        cyc();

        // Same-cycle write and read of register 3
        RegWrite = 1'b1; rd = 5'd3; WriteData = 64'hAA; rs1 = 5'd3; rs2 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp1", ReadData1, 64'hAA);
        check("byp2", ReadData2, 64'hAA);
`else
        check("old1", ReadData1, 64'd3);
        check("old2", ReadData2, 64'd3);
`endif
        cyc();
        RegWrite = 1'b0;
        #1;
        check("new3", ReadData1, 64'hAA);
        cyc();

        // init_req with a write in the same cycle; writes during INIT ignored
        RegWrite = 1'b1; rd = 5'd9; WriteData = 64'h55;
        cyc();
        RegWrite = 1'b1; rd = 5'd12; WriteData = 64'h66; init_req = 1'b1; rs1 = 5'd12;
        cyc();
        init_req = 1'b0; rs1 = 5'd9; rs2 = 5'd4;
        for (int c = 0; c < DEPTH; c++) begin
            RegWrite = (c < 4); rd = 5'd4; WriteData = 64'h77;
            cyc();
        end
        idle_inputs();
        #1;
        check("ri9", ReadData1, 64'd9);
        check("ri4", ReadData2, 64'd4);
        cyc();

        // Reset in the middle of INIT
        init_req = 1'b1;
        cyc();
        init_req = 1'b0; rs1 = 5'd5; rs2 = 5'd6;
        for (int c = 0; c < 10; c++) cyc();
        set_reset(1'b1);
        #1;
        check("rst_rdy", {63'd0, ready}, 64'd0);
        check("rst_rd1", ReadData1, 64'd0);
        cyc();
        cyc();
        set_reset(1'b0);
        for (int c = 0; c < DEPTH; c++) cyc();
        #1;
        check("rst_back", {63'd0, ready}, 64'd1);

        // Randomised traffic
        for (int c = 0; c < 400; c++) begin
            RegWrite  = 1'($urandom_range(1));
            rd        = 5'($urandom_range(31));
            WriteData = {$urandom, $urandom};
            init_req  = ($urandom_range(59) == 0);
            rs1       = ($urandom_range(3) == 0) ? rd : 5'($urandom_range(31));
            rs2       = ($urandom_range(3) == 0) ? rd : 5'($urandom_range(31));
            cyc();
        end
        idle_inputs();
        for (int c = 0; c < DEPTH + 2; c++) cyc();

        // Asynchronous reset while READY drops outputs at once
        rs1 = 5'd5; rs2 = 5'd7;
        #1;
        check("pre_rst", {63'd0, ready}, 64'd1);
        set_reset(1'b1);
        #1;
        check("arst_rdy", {63'd0, ready}, 64'd0);
        check("arst_rd1", ReadData1, 64'd0);
        check("arst_rd2", ReadData2, 64'd0);
        check("arst_rdy2", {63'd0, rdy2}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
